// File: rtl/router_pe_port_pkg.sv
// Shared constants for the router-side PE link port: default packet width
// and the virtual-channel encoding carried in packet bit 0.
package router_pe_port_pkg;

    localparam int DEFAULT_DATA_W = 64;

    // VC bit values: even packets use buffer 0, odd packets use buffer 1.
    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    // Packets are numbered MSB-first [0:DATA_W-1]; the VC bit is bit 0.
    localparam int VC_BIT = 0;

endpackage

// File: rtl/router_pe_port_vc_slot.sv
// Single-entry packet buffer with a full flag. Load writes the entry and sets
// full; clear empties it. The owner never loads a full slot, so load and
// clear are never both asserted.
module vc_slot
    import router_pe_port_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [0:DATA_W-1] din,
    output logic [0:DATA_W-1] dout,
    output logic              full
);

    logic [0:DATA_W-1] data_q;

    // Full flag: set on load, cleared on drain, emptied by reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

    // Packet storage: captured on load only.
    always_ff @(posedge clk) begin
        // NOTE: the payload is not reset; the full flag alone says whether it is meaningful.
        if (load) begin
            data_q <= din;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/router_pe_port.sv
// Router-side endpoint of the NIC link. Ingress packets from the NIC land in
// per-VC buffers and are offered to the switch with round-robin arbitration;
// egress packets from the switch land in per-VC buffers and cross the link
// when their VC matches the active link VC (the inverse of polarity).
module router_pe_port
    import router_pe_port_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              polarity,
    input  logic              pe_si,
    output logic              pe_ri,
    input  logic [0:DATA_W-1] pe_di,
    output logic              pe_so,
    input  logic              pe_ro,
    output logic [0:DATA_W-1] pe_do,
    output logic              sw_out_valid,
    input  logic              sw_out_ready,
    output logic [0:DATA_W-1] sw_out_data,
    input  logic              sw_in_valid,
    output logic              sw_in_ready,
    input  logic [0:DATA_W-1] sw_in_data,
    output logic              proto_err
);

    logic              av;          // active link VC
    logic              rr;          // VC that wins when both ingress buffers are full
    logic              sel;         // ingress VC presented to the switch
    logic              ev;          // VC of the packet offered by the switch
    logic              link_in;     // NIC-to-router transfer this cycle
    logic              sw_pop;      // switch takes the ingress packet this cycle
    logic [1:0]        ib_full, ib_load, ib_clear;
    logic [1:0]        eb_full, eb_load, eb_clear;
    logic [0:DATA_W-1] ib_data [2];
    logic [0:DATA_W-1] eb_data [2];

    assign av = ~polarity;

    // Ingress side: link handshake, buffer select and switch pop.
    always_comb begin
        // NOTE: every signal gets a default before any conditional write so no latch is inferred.
        ib_load      = '0;
        ib_clear     = '0;
        pe_ri        = ~ib_full[av];
        link_in      = pe_si & ~ib_full[av];
        ib_load[av]  = link_in;
        sw_out_valid = |ib_full;
        sel          = (&ib_full) ? rr : ib_full[VC_ODD];
        sw_out_data  = ib_data[sel];
        sw_pop       = sw_out_valid & sw_out_ready;
        ib_clear[sel] = sw_pop;
    end

    // Egress side: switch push into the packet's VC buffer, link delivery on the active VC.
    always_comb begin
        eb_load      = '0;
        eb_clear     = '0;
        ev           = sw_in_data[VC_BIT];
        sw_in_ready  = ~eb_full[ev];
        eb_load[ev]  = sw_in_valid & ~eb_full[ev];
        pe_so        = eb_full[av] & pe_ro;
        pe_do        = eb_data[av];
        eb_clear[av] = pe_so;
    end

    // Polarity toggles every cycle; rr passes priority to the other VC after a pop;
    // proto_err latches a NIC packet whose VC bit disagrees with the active VC.
    always_ff @(posedge clk) begin
        if (reset) begin
            polarity  <= 1'b0;
            rr        <= VC_EVEN;
            proto_err <= 1'b0;
        end else begin
            polarity <= ~polarity;
            if (sw_pop) begin
                rr <= ~sel;
            end
            if (link_in && (pe_di[VC_BIT] != av)) begin
                proto_err <= 1'b1;
            end
        end
    end

    vc_slot #(.DATA_W(DATA_W)) ib0 (
        .clk   (clk),
        .reset (reset),
        .load  (ib_load[VC_EVEN]),
        .clear (ib_clear[VC_EVEN]),
        .din   (pe_di),
        .dout  (ib_data[VC_EVEN]),
        .full  (ib_full[VC_EVEN])
    );

    vc_slot #(.DATA_W(DATA_W)) ib1 (
        .clk   (clk),
        .reset (reset),
        .load  (ib_load[VC_ODD]),
        .clear (ib_clear[VC_ODD]),
        .din   (pe_di),
        .dout  (ib_data[VC_ODD]),
        .full  (ib_full[VC_ODD])
    );

    vc_slot #(.DATA_W(DATA_W)) eb0 (
        .clk   (clk),
        .reset (reset),
        .load  (eb_load[VC_EVEN]),
        .clear (eb_clear[VC_EVEN]),
        .din   (sw_in_data),
        .dout  (eb_data[VC_EVEN]),
        .full  (eb_full[VC_EVEN])
    );

    vc_slot #(.DATA_W(DATA_W)) eb1 (
        .clk   (clk),
        .reset (reset),
        .load  (eb_load[VC_ODD]),
        .clear (eb_clear[VC_ODD]),
        .din   (sw_in_data),
        .dout  (eb_data[VC_ODD]),
        .full  (eb_full[VC_ODD])
    );

endmodule

// File: tb/tb_router_pe_port.sv
// Scoreboard bench for router_pe_port. Directed stimulus pushes expected
// packets into per-direction queues; monitors pop and compare whenever the
// DUT hands a packet to the switch or to the NIC.
module tb_router_pe_port;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         polarity;
    logic         pe_si;
    logic         pe_ri;
    logic [0:W-1] pe_di;
    logic         pe_so;
    logic         pe_ro;
    logic [0:W-1] pe_do;
    logic         sw_out_valid;
    logic         sw_out_ready;
    logic [0:W-1] sw_out_data;
    logic         sw_in_valid;
    logic         sw_in_ready;
    logic [0:W-1] sw_in_data;
    logic         proto_err;

    int compared   = 0;
    int mismatched = 0;

    logic [0:W-1] sw_q [$];   // expected packets toward the switch
    logic [0:W-1] pe_q [$];   // expected packets toward the NIC
    logic         mp;         // bench's own polarity model, used for sequencing

    router_pe_port #(.DATA_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .polarity     (polarity),
        .pe_si        (pe_si),
        .pe_ri        (pe_ri),
        .pe_di        (pe_di),
        .pe_so        (pe_so),
        .pe_ro        (pe_ro),
        .pe_do        (pe_do),
        .sw_out_valid (sw_out_valid),
        .sw_out_ready (sw_out_ready),
        .sw_out_data  (sw_out_data),
        .sw_in_valid  (sw_in_valid),
        .sw_in_ready  (sw_in_ready),
        .sw_in_data   (sw_in_data),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mp <= reset ? 1'b0 : ~mp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Switch-side monitor.
    always @(negedge clk) begin
        if (reset === 1'b0 && sw_out_valid && sw_out_ready) begin
            if (sw_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sw_out_unexpected: got %h, expected no packet", sw_out_data);
            end else begin
                check("sw_out_data", sw_out_data, sw_q.pop_front());
            end
        end
    end

    // NIC-side monitor.
    always @(negedge clk) begin
        if (reset === 1'b0 && pe_so) begin
            if (pe_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL pe_do_unexpected: got %h, expected no packet", pe_do);
            end else begin
                check("pe_do", pe_do, pe_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to just after an edge where the link polarity equals p.
    task automatic to_pol(input logic p);
        step();
        if (mp != p) step();
    endtask

    localparam logic [0:W-1] PA = 64'h8000_0000_0000_00AB;
    localparam logic [0:W-1] PB = 64'hC000_0000_0000_0011;
    localparam logic [0:W-1] PC = 64'h0000_0000_0000_0022;
    localparam logic [0:W-1] PD = 64'h0000_0000_0000_1234;
    localparam logic [0:W-1] PE = 64'h0000_0000_0000_5678;
    localparam logic [0:W-1] PF = 64'h8000_0000_0000_9999;
    localparam logic [0:W-1] PG = 64'h0000_0000_0000_0077;
    localparam logic [0:W-1] H1 = 64'hA000_0000_0000_0001;
    localparam logic [0:W-1] H0 = 64'h1000_0000_0000_0002;
    localparam logic [0:W-1] J0 = 64'h0000_0000_0000_0AAA;
    localparam logic [0:W-1] J1 = 64'hF000_0000_0000_0BBB;

    initial begin
        reset        = 1'b1;
        pe_si        = 1'b0;
        pe_di        = '0;
        pe_ro        = 1'b0;
        sw_out_ready = 1'b0;
        sw_in_valid  = 1'b0;
        sw_in_data   = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset: polarity 0,1,0,1 and quiescent handshakes.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_polarity", polarity, 64'(i % 2));
            check("idle_pe_ri", pe_ri, 1);
            check("idle_pe_so", pe_so, 0);
            check("idle_sw_out_valid", sw_out_valid, 0);
            check("idle_sw_in_ready", sw_in_ready, 1);
            check("idle_proto_err", proto_err, 0);
        end

        // Single odd ingress packet, visible to the switch one cycle later.
        sw_out_ready = 1'b1;
        to_pol(1'b0);
        pe_si = 1'b1;
        pe_di = PA;
        sw_q.push_back(PA);
        @(negedge clk);
        check("t2_valid_before", sw_out_valid, 0);
        step();
        pe_si = 1'b0;
        @(negedge clk);
        check("t2_valid", sw_out_valid, 1);
        check("t2_pe_ri_vc0", pe_ri, 1);
        step();
        @(negedge clk);
        check("t2_popped", sw_out_valid, 0);
        check("t2_proto_err", proto_err, 0);

        // Both ingress VCs full; rr is 0 after the odd pop, so even drains first.
        sw_out_ready = 1'b0;
        sw_q.push_back(PC);
        sw_q.push_back(PB);
        to_pol(1'b0);
        pe_si = 1'b1;
        pe_di = PB;
        step();
        pe_di = PC;
        step();
        pe_si = 1'b0;
        @(negedge clk);
        check("t3_pe_ri_pol0", pe_ri, 0);
        check("t3_valid", sw_out_valid, 1);
        step();
        @(negedge clk);
        check("t3_pe_ri_pol1", pe_ri, 0);
        step();
        sw_out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check("t3_drained", sw_out_valid, 0);

        // Egress even packet crosses while polarity is 1.
        pe_ro = 1'b1;
        to_pol(1'b0);
        sw_in_valid = 1'b1;
        sw_in_data  = PD;
        pe_q.push_back(PD);
        @(negedge clk);
        check("t4_sw_in_ready", sw_in_ready, 1);
        check("t4_pe_so_early", pe_so, 0);
        step();
        sw_in_valid = 1'b0;
        @(negedge clk);
        check("t4_polarity", polarity, 1);
        check("t4_pe_so", pe_so, 1);
        check("t4_sw_in_ready_full", sw_in_ready, 0);
        step();
        @(negedge clk);
        check("t4_sw_in_ready_back", sw_in_ready, 1);
        check("t4_pe_so_done", pe_so, 0);

        // With pe_ro low the egress packet is held.
        step();
        pe_ro       = 1'b0;
        sw_in_valid = 1'b1;
        sw_in_data  = PE;
        step();
        sw_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_hold_pe_so", pe_so, 0);
            check("t4_hold_ready", sw_in_ready, 0);
            step();
        end
        pe_q.push_back(PE);
        pe_ro = 1'b1;
        for (int i = 0; i < 4 && pe_q.size() != 0; i++) step();
        check("t4_hold_release", 64'(pe_q.size()), 0);

        // Odd egress packet waits for polarity 0.
        to_pol(1'b0);
        sw_in_valid = 1'b1;
        sw_in_data  = PF;
        pe_q.push_back(PF);
        step();
        sw_in_valid = 1'b0;
        @(negedge clk);
        check("t4_odd_wait", pe_so, 0);
        step();
        @(negedge clk);
        check("t4_odd_go", pe_so, 1);
        step();

        // VC bit mismatch: packet still stored in the active VC buffer, error is sticky.
        to_pol(1'b0);
        pe_si = 1'b1;
        pe_di = PG;
        sw_q.push_back(PG);
        step();
        pe_si = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_proto_err", proto_err, 1);
            step();
        end

        // Fill all four buffers, then reset.
        sw_out_ready = 1'b0;
        pe_ro        = 1'b0;
        to_pol(1'b0);
        pe_si       = 1'b1;
        pe_di       = H1;
        sw_in_valid = 1'b1;
        sw_in_data  = J0;
        step();
        pe_di      = H0;
        sw_in_data = J1;
        step();
        pe_si       = 1'b0;
        sw_in_valid = 1'b0;
        @(negedge clk);
        check("t6_full_valid", sw_out_valid, 1);
        check("t6_full_pe_ri", pe_ri, 0);
        check("t6_full_ready_j1", sw_in_ready, 0);
        step();
        sw_in_data = J0;
        reset      = 1'b1;
        @(negedge clk);
        check("t6_full_ready_j0", sw_in_ready, 0);
        step();
        reset        = 1'b0;
        pe_ro        = 1'b1;
        sw_out_ready = 1'b1;
        @(negedge clk);
        check("t6_polarity", polarity, 0);
        check("t6_sw_out_valid", sw_out_valid, 0);
        check("t6_pe_so", pe_so, 0);
        check("t6_pe_ri", pe_ri, 1);
        check("t6_ready_j0", sw_in_ready, 1);
        check("t6_proto_err", proto_err, 0);
        step();
        sw_in_data = J1;
        @(negedge clk);
        check("t6_polarity_next", polarity, 1);
        check("t6_pe_so_next", pe_so, 0);
        check("t6_sw_out_valid_next", sw_out_valid, 0);
        check("t6_ready_j1", sw_in_ready, 1);
        step();

        check("sw_q_empty", 64'(sw_q.size()), 0);
        check("pe_q_empty", 64'(pe_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
